// File: rtl/exc_seq_pkg.sv
// Shared types and constants for the exception entry/return sequencer.
package exc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BAK  = 2'd1,
    ST_VEC  = 2'd2,
    ST_RET  = 2'd3
  } state_t;

  typedef enum logic {
    CAUSE_SWI = 1'b0,
    CAUSE_IRQ = 1'b1
  } cause_t;

  localparam logic [31:0] DEF_IRQ_VEC = 32'h0000_0018;
  localparam logic [31:0] DEF_SWI_VEC = 32'h0000_0008;

  // IRQ returns past the interrupted instruction, SWI returns to the next one.
  function automatic logic [31:0] entry_lr(input cause_t cause, input logic [31:0] pc_next);
    entry_lr = (cause == CAUSE_IRQ) ? (pc_next + 32'd4) : pc_next;
  endfunction

endpackage

// File: rtl/exc_seq_sync2.sv
// Two-flop synchronizer for the asynchronous IRQ level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/exc_seq.sv
// Exception sequencer: takes SWI/IRQ entries at instruction boundaries (SPSR
// backup, LR write, vector fetch) and handles exception returns (SPSR restore).
module exc_seq
  import exc_seq_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
  parameter logic [31:0] SWI_VEC = DEF_SWI_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_irq,
  input  logic        i_irq_mask,
  input  logic        i_int_mode,
  input  logic        i_boundary,
  input  logic        i_swi,
  input  logic        i_ret_req,
  input  logic [31:0] i_pc_next,
  output logic        o_spsr_bak,
  output logic        o_spsr_res,
  output logic        o_lr_we,
  output logic [31:0] o_lr,
  output logic        o_vec_valid,
  output logic [31:0] o_vec_addr,
  input  logic        i_vec_ready,
  output logic        o_busy,
  output logic        o_irq_pend,
  output logic [7:0]  o_irq_cnt
);

  state_t      state_reg, state_next;
  cause_t      cause_reg, cause_next;
  logic [31:0] lr_reg, lr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        irq_sync;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_irq),
    .q     (irq_sync)
  );

  assign o_irq_pend = irq_sync & ~i_irq_mask & ~i_int_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cause_reg <= CAUSE_SWI;
      lr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      lr_reg    <= lr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    lr_next    = lr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        // SWI beats IRQ, and any entry beats a return in the same cycle.
        if (en && i_boundary && i_swi) begin
          state_next = ST_BAK;
          cause_next = CAUSE_SWI;
          lr_next    = entry_lr(CAUSE_SWI, i_pc_next);
        end else if (en && i_boundary && o_irq_pend) begin
          state_next = ST_BAK;
          cause_next = CAUSE_IRQ;
          lr_next    = entry_lr(CAUSE_IRQ, i_pc_next);
          cnt_next   = cnt_reg + 8'd1;
        end else if (en && i_ret_req && i_int_mode) begin
          state_next = ST_RET;
        end
      end
      ST_BAK: begin
        if (en) state_next = ST_VEC;
      end
      ST_VEC: begin
        if (en && i_vec_ready) state_next = ST_IDLE;
      end
      ST_RET: begin
        if (en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so they hold while en is low.
  assign o_spsr_bak  = (state_reg == ST_BAK);
  assign o_lr_we     = (state_reg == ST_BAK);
  assign o_lr        = (state_reg == ST_BAK) ? lr_reg : 32'd0;
  assign o_spsr_res  = (state_reg == ST_RET);
  assign o_vec_valid = (state_reg == ST_VEC);
  assign o_vec_addr  = (state_reg != ST_VEC)    ? 32'd0 :
                       (cause_reg == CAUSE_IRQ) ? IRQ_VEC : SWI_VEC;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_irq_cnt   = cnt_reg;

endmodule

// File: tb/tb_exc_seq.sv
// Scoreboard bench for exc_seq: stimulus pushes expected LR/vector/return
// transactions; a negedge monitor pops and compares them as the DUT emits them.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        i_irq = 1'b0;
  logic        i_irq_mask = 1'b0;
  logic        i_int_mode = 1'b0;
  logic        i_boundary = 1'b0;
  logic        i_swi = 1'b0;
  logic        i_ret_req = 1'b0;
  logic [31:0] i_pc_next = 32'd0;
  logic        i_vec_ready = 1'b1;
  logic        o_spsr_bak, o_spsr_res, o_lr_we, o_vec_valid, o_busy, o_irq_pend;
  logic [31:0] o_lr, o_vec_addr;
  logic [7:0]  o_irq_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum int { K_LR = 0, K_VEC = 1, K_RET = 2 } kind_t;
  typedef struct { kind_t kind; logic [31:0] data; } item_t;
  item_t exp_q[$];

  exc_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .i_irq       (i_irq),
    .i_irq_mask  (i_irq_mask),
    .i_int_mode  (i_int_mode),
    .i_boundary  (i_boundary),
    .i_swi       (i_swi),
    .i_ret_req   (i_ret_req),
    .i_pc_next   (i_pc_next),
    .o_spsr_bak  (o_spsr_bak),
    .o_spsr_res  (o_spsr_res),
    .o_lr_we     (o_lr_we),
    .o_lr        (o_lr),
    .o_vec_valid (o_vec_valid),
    .o_vec_addr  (o_vec_addr),
    .i_vec_ready (i_vec_ready),
    .o_busy      (o_busy),
    .o_irq_pend  (o_irq_pend),
    .o_irq_cnt   (o_irq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input kind_t k, input logic [31:0] d);
    item_t it;
    it.kind = k;
    it.data = d;
    exp_q.push_back(it);
  endtask

  task automatic take(input kind_t k, input logic [31:0] d);
    item_t it;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_txn: got kind %0d data %h want none", k, d);
    end else begin
      it = exp_q.pop_front();
      if (it.kind != k || it.data !== d) begin
        n_bad++;
        $display("FAIL txn: got kind %0d data %h want kind %0d data %h", k, d, it.kind, it.data);
      end else begin
        $display("txn kind %0d data %h ok", k, d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && en) begin
      if (o_lr_we) begin
        take(K_LR, o_lr);
        chk("bak_with_lr", {31'd0, o_spsr_bak}, 32'd1);
      end
      if (o_vec_valid && i_vec_ready) take(K_VEC, o_vec_addr);
      if (o_spsr_res) take(K_RET, 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_spsr_bak, o_spsr_res, o_lr_we, o_vec_valid, o_busy, o_irq_pend, o_irq_cnt},
        32'd0);
    chk({name, "_lr"}, o_lr, 32'd0);
    chk({name, "_vaddr"}, o_vec_addr, 32'd0);
  endtask

  task automatic swi_entry(input logic [31:0] pc);
    i_swi = 1'b1;
    i_boundary = 1'b1;
    i_pc_next = pc;
    tick();
    i_swi = 1'b0;
    i_boundary = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // IRQ entry: pend after 2 clocks, LR = pc+4, IRQ vector, count 1
    i_irq = 1'b1;
    i_pc_next = 32'h100;
    tick();
    chk("pend_1clk", o_irq_pend, 1'b0);
    tick();
    chk("pend_2clk", o_irq_pend, 1'b1);
    tick();
    chk("no_entry_wo_boundary", o_busy, 1'b0);
    push(K_LR, 32'h104);
    push(K_VEC, 32'h18);
    i_boundary = 1'b1;
    tick();
    i_boundary = 1'b0;
    i_irq = 1'b0;
    chk("irq_bak_busy", o_busy, 1'b1);
    drain("irq");
    chk("irq_cnt", o_irq_cnt, 8'd1);
    chk("irq_idle", o_busy, 1'b0);

    // SWI and IRQ together: SWI wins, count unchanged
    i_irq = 1'b1;
    tick(2);
    push(K_LR, 32'h200);
    push(K_VEC, 32'h08);
    i_irq = 1'b0;
    swi_entry(32'h200);
    drain("swi_prio");
    chk("swi_cnt", o_irq_cnt, 8'd1);
    tick(2);

    // Vector stall: ready low for 3 cycles keeps request stable
    i_vec_ready = 1'b0;
    push(K_LR, 32'h300);
    push(K_VEC, 32'h08);
    swi_entry(32'h300);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", o_vec_valid, 1'b1);
      chk("stall_addr", o_vec_addr, 32'h08);
      tick();
    end
    i_vec_ready = 1'b1;
    drain("stall");
    chk("stall_idle", o_busy, 1'b0);

    // Exception return in exception mode, ignored outside it
    i_int_mode = 1'b1;
    i_ret_req = 1'b1;
    push(K_RET, 32'd0);
    tick();
    i_ret_req = 1'b0;
    chk("ret_res", o_spsr_res, 1'b1);
    drain("ret");
    chk("ret_done", {o_spsr_res, o_busy}, 2'b00);
    i_int_mode = 1'b0;
    i_ret_req = 1'b1;
    tick(2);
    chk("ret_ignored", {o_spsr_res, o_busy}, 2'b00);
    i_ret_req = 1'b0;

    // Mask suppresses pend
    i_irq = 1'b1;
    i_irq_mask = 1'b1;
    tick(3);
    chk("masked_pend", o_irq_pend, 1'b0);
    i_irq_mask = 1'b0;
    #1;
    chk("unmasked_pend", o_irq_pend, 1'b1);
    i_irq = 1'b0;
    tick(3);

    // en low: no entry from IDLE, BAK held with pulses still visible
    en = 1'b0;
    i_swi = 1'b1;
    i_boundary = 1'b1;
    tick();
    chk("en0_no_entry", o_busy, 1'b0);
    en = 1'b1;
    i_swi = 1'b0;
    i_boundary = 1'b0;
    push(K_LR, 32'h400);
    push(K_VEC, 32'h08);
    swi_entry(32'h400);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("en0_bak", {o_spsr_bak, o_lr_we, o_vec_valid}, 3'b110);
      chk("en0_lr", o_lr, 32'h400);
    end
    en = 1'b1;
    drain("en0");

    // Reset during VEC abandons the sequence
    i_irq = 1'b1;
    tick(2);
    i_vec_ready = 1'b0;
    push(K_LR, 32'h504);
    i_boundary = 1'b1;
    i_pc_next = 32'h500;
    tick();
    i_boundary = 1'b0;
    i_irq = 1'b0;
    tick();
    chk("pre_rst_valid", o_vec_valid, 1'b1);
    chk("pre_rst_cnt", o_irq_cnt, 8'd2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    i_vec_ready = 1'b1;
    tick(3);
    chk("post_rst_valid", {o_vec_valid, o_busy}, 2'b00);
    chk("post_rst_q", exp_q.size(), 32'd0);

    // 256 IRQ entries wrap the counter; last one wraps LR past 2^32
    i_irq = 1'b1;
    tick(2);
    for (int i = 0; i < 256; i++) begin
      i_pc_next = (i == 255) ? 32'hFFFF_FFFE : 32'(i * 16);
      push(K_LR, i_pc_next + 32'd4);
      push(K_VEC, 32'h18);
      i_boundary = 1'b1;
      tick();
      i_boundary = 1'b0;
      tick(2);
      if (i == 254) chk("cnt_ff", o_irq_cnt, 8'hFF);
    end
    i_irq = 1'b0;
    drain("wrap");
    chk("cnt_wrap", o_irq_cnt, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
